// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared constants and types for the multi-port register file.
//   XLEN_DEF / NREG_DEF / NRD_DEF / NWR_DEF : default geometry
//   ZERO_REG                                : index of the hard-wired zero register
//   reg_addr_t                              : register index type for the default NREG
package reg_file_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  localparam int ZERO_REG = 0;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode/writeback bundle of the register file.
//   master : decode + writeback side (drives addresses, writes, issue, flush)
//   slave  : register file side (returns read data and busy flags)
// Signals: pipeline_en, rd_addr/rd_data/rd_busy (NRD ports),
//          wr_en/wr_addr/wr_data (NWR ports), iss_en/iss_addr, flush.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF
);
  localparam int AW = $clog2(NREG);

  logic                          pipeline_en;
  logic [NRD-1:0][AW-1:0]        rd_addr;
  logic [NRD-1:0][XLEN-1:0]      rd_data;
  logic [NRD-1:0]                rd_busy;
  logic [NWR-1:0]                wr_en;
  logic [NWR-1:0][AW-1:0]        wr_addr;
  logic [NWR-1:0][XLEN-1:0]      wr_data;
  logic                          iss_en;
  logic [AW-1:0]                 iss_addr;
  logic                          flush;

  modport master (
    output pipeline_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  pipeline_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy (pending writeback) tracking.
//   clk, rst_n           : clock, asynchronous active-low reset
//   pipeline_en, flush   : advance enable, squash (clears all busy bits)
//   wr_en/wr_addr        : writebacks, clear the busy bit of their target
//   iss_en/iss_addr      : issuing destination, sets its busy bit
//   rd_addr -> rd_busy   : per read port busy lookup
// A register being written back this cycle is reported not busy, since the
// read side receives the bypassed value.
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = NWR_DEF,
  parameter int NRD  = NRD_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipeline_en,
  input  logic                   flush,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0]         rd_busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] wb_hit;

  // Registers targeted by an effective writeback this cycle.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (pipeline_en && wr_en[i]) wb_hit[wr_addr[i]] = 1'b1;
    end
    wb_hit[ZERO_REG] = 1'b0;
  end

  // Clear first, then set: a same-cycle issue is the newer producer.
  // Flush overrides everything.
  always_comb begin
    busy_next = busy_reg;
    if (pipeline_en) begin
      busy_next = busy_reg & ~wb_hit;
      if (iss_en) busy_next[iss_addr] = 1'b1;
    end
    if (flush) busy_next = '0;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_busy[j] = busy_reg[rd_addr[j]] && !wb_hit[rd_addr[j]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with write-to-read
// bypass and busy scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_file_mp_if.slave (reads, writes, issue, flush, enable)
// Optional (macro REG_FILE_MP_DBG_PORT_EN): dbg_en, dbg_we, dbg_addr,
//   dbg_wdata, dbg_rdata -- unbypassed debug access to the storage.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_mp_if.slave      bus
`ifdef REG_FILE_MP_DBG_PORT_EN
  ,
  input  logic              dbg_en,
  input  logic              dbg_we,
  input  logic [AW-1:0]     dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic [XLEN-1:0]   dbg_rdata
`endif
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] reg_we;
  logic [XLEN-1:0] reg_wd [NREG];
  wire  [NRD-1:0][XLEN-1:0] rd_data_w;

  // Per-register write selection. Pipeline ports are applied after the
  // debug port so they win, and higher port indices win among themselves.
  always_comb begin
    reg_we = '0;
    reg_wd = '{default: '0};
`ifdef REG_FILE_MP_DBG_PORT_EN
    if (dbg_en && dbg_we) begin
      reg_we[dbg_addr] = 1'b1;
      reg_wd[dbg_addr] = dbg_wdata;
    end
`endif
    if (bus.pipeline_en) begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i]) begin
          reg_we[bus.wr_addr[i]] = 1'b1;
          reg_wd[bus.wr_addr[i]] = bus.wr_data[i];
        end
      end
    end
    reg_we[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_reg[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (reg_we[r]) regs_reg[r] <= reg_wd[r];
      end
    end
  end

  // Read ports: bypass from the highest-indexed matching write port.
  // Outputs are forced to zero while reset is asserted so a bypass cannot
  // leak data during reset.
  genvar gi;
  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [XLEN-1:0] rd_val;
    always_comb begin
      rd_val = regs_reg[bus.rd_addr[gi]];
      for (int i = 0; i < NWR; i++) begin
        if (bus.pipeline_en && bus.wr_en[i] && (bus.wr_addr[i] == bus.rd_addr[gi]))
          rd_val = bus.wr_data[i];
      end
      if (!rst_n || (bus.rd_addr[gi] == AW'(ZERO_REG))) rd_val = '0;
    end
    assign rd_data_w[gi] = rd_val;
  end

  assign bus.rd_data = rd_data_w;

`ifdef REG_FILE_MP_DBG_PORT_EN
  assign dbg_rdata = regs_reg[dbg_addr];
`endif

  reg_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipeline_en (bus.pipeline_en),
    .flush       (bus.flush),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .iss_en      (bus.iss_en),
    .iss_addr    (bus.iss_addr),
    .rd_addr     (bus.rd_addr),
    .rd_busy     (bus.rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against a
// behavioural model (array of values + array of busy flags).
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  localparam int XLEN = XLEN_DEF;
  localparam int NREG = NREG_DEF;
  localparam int NRD  = NRD_DEF;
  localparam int NWR  = NWR_DEF;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

`ifdef REG_FILE_MP_DBG_PORT_EN
  logic            dbg_en;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic [XLEN-1:0] dbg_rdata;
`endif

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef REG_FILE_MP_DBG_PORT_EN
    ,
    .dbg_en    (dbg_en),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural values and pending-producer flags.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Value a reader must see right now: newest in-flight write, else stored.
  function automatic logic [XLEN-1:0] exp_rd(input int a);
    logic [XLEN-1:0] v;
    if (!rst_n || a == 0) return '0;
    v = m_regs[a];
    if (bus.pipeline_en)
      for (int i = 0; i < NWR; i++)
        if (bus.wr_en[i] && int'(bus.wr_addr[i]) == a) v = bus.wr_data[i];
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    if (!rst_n || a == 0) return 1'b0;
    if (bus.pipeline_en)
      for (int i = 0; i < NWR; i++)
        if (bus.wr_en[i] && int'(bus.wr_addr[i]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply the rules of one rising edge using the inputs held across it.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef REG_FILE_MP_DBG_PORT_EN
    if (dbg_en && dbg_we && dbg_addr != 0) m_regs[dbg_addr] = dbg_wdata;
`endif
    if (bus.pipeline_en) begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i] && bus.wr_addr[i] != 0) begin
          m_regs[bus.wr_addr[i]] = bus.wr_data[i];
          m_busy[bus.wr_addr[i]] = 1'b0;
        end
      end
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
    end
    if (bus.flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    bus.pipeline_en = 1'b1;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.iss_en      = 1'b0;
    bus.iss_addr    = '0;
    bus.flush       = 1'b0;
`ifdef REG_FILE_MP_DBG_PORT_EN
    dbg_en = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`endif
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = AW'(a);
    bus.wr_data[p] = d;
  endtask

  task automatic check_model(input string tag);
    for (int j = 0; j < NRD; j++) begin
      chk($sformatf("%s_rd%0d", tag, j), bus.rd_data[j], exp_rd(int'(bus.rd_addr[j])));
      chk($sformatf("%s_busy%0d", tag, j), {{(XLEN-1){1'b0}}, bus.rd_busy[j]},
          {{(XLEN-1){1'b0}}, exp_busy(int'(bus.rd_addr[j]))});
    end
`ifdef REG_FILE_MP_DBG_PORT_EN
    chk($sformatf("%s_dbg", tag), dbg_rdata, m_regs[dbg_addr]);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reg_addr_t ra;
    model_reset();
    idle();
    bus.rd_addr = '0;

    // Reset state, with a write to x5 being bypassed while reset is held.
    bus.rd_addr[0] = AW'(5); bus.rd_addr[1] = AW'(5);
    wr(0, 5, 32'hCAFE);
    @(negedge clk);
    chk("reset_rd0", bus.rd_data[0], 32'h0);
    chk("reset_rd1", bus.rd_data[1], 32'h0);
    chk("reset_busy", {30'b0, bus.rd_busy}, 32'h0);
    $display("step reset: read x5 on both ports while reset held");
    tick();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("reset_x5_stays0", bus.rd_data[0], 32'h0);

    // Reset asserted mid-write discards the write.
    wr(1, 5, 32'hBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("midreset_x5", bus.rd_data[0], 32'h0);
    $display("step mid-reset write to x5 discarded");

    // Same-address double write: highest port wins, in bypass and storage.
    idle();
    wr(0, 3, 32'h1111); wr(1, 3, 32'h2222);
    bus.rd_addr[0] = AW'(3);
    @(negedge clk);
    chk("x3_bypass", bus.rd_data[0], 32'h2222);
    tick(); idle();
    @(negedge clk);
    chk("x3_stored", bus.rd_data[0], 32'h2222);
    $display("step dual write x3");

    // x0 is hard-wired: ignored write and issue.
    wr(0, 0, 32'hDEAD); bus.iss_en = 1'b1; bus.iss_addr = '0;
    bus.rd_addr[0] = '0;
    @(negedge clk);
    chk("x0_bypass", bus.rd_data[0], 32'h0);
    chk("x0_busy_now", {31'b0, bus.rd_busy[0]}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("x0_stored", bus.rd_data[0], 32'h0);
    chk("x0_busy_next", {31'b0, bus.rd_busy[0]}, 32'h0);
    $display("step write/issue x0 ignored");

    // pipeline_en low: no write, no bypass.
    bus.pipeline_en = 1'b0; wr(0, 7, 32'hAB);
    bus.rd_addr[0] = AW'(7);
    @(negedge clk);
    chk("x7_nobypass", bus.rd_data[0], 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("x7_unchanged", bus.rd_data[0], 32'h0);
    $display("step x7 write with pipeline_en low");

    // Issue x9, wait, then writeback while reading.
    bus.iss_en = 1'b1; bus.iss_addr = AW'(9);
    bus.rd_addr[1] = AW'(9);
    tick(); idle();
    @(negedge clk);
    chk("x9_busy_before_wb", {31'b0, bus.rd_busy[1]}, 32'h1);
    tick();
    wr(1, 9, 32'h55);
    @(negedge clk);
    chk("x9_busy_at_wb", {31'b0, bus.rd_busy[1]}, 32'h0);
    chk("x9_data_at_wb", bus.rd_data[1], 32'h55);
    tick(); idle();
    @(negedge clk);
    chk("x9_busy_after", {31'b0, bus.rd_busy[1]}, 32'h0);
    $display("step issue/writeback x9");

    // Same-cycle issue and writeback of x4 leaves it busy; flush clears all.
    bus.iss_en = 1'b1; bus.iss_addr = AW'(4); wr(0, 4, 32'h44);
    tick(); idle();
    bus.rd_addr[0] = AW'(4); bus.rd_addr[1] = AW'(6);
    @(negedge clk);
    chk("x4_busy_kept", {31'b0, bus.rd_busy[0]}, 32'h1);
    bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_addr = AW'(6);
    tick(); idle();
    @(negedge clk);
    chk("x4_flushed", {31'b0, bus.rd_busy[0]}, 32'h0);
    chk("x6_flushed", {31'b0, bus.rd_busy[1]}, 32'h0);
    $display("step issue+wb x4, flush with issue x6");

`ifdef REG_FILE_MP_DBG_PORT_EN
    // Debug write ignores pipeline_en; pipeline write wins over it.
    bus.pipeline_en = 1'b0;
    dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = AW'(10); dbg_wdata = 32'h77;
    tick(); idle(); dbg_addr = AW'(10);
    @(negedge clk);
    chk("dbg_x10_77", dbg_rdata, 32'h77);
    dbg_en = 1'b1; dbg_we = 1'b1; dbg_wdata = 32'h11;
    wr(0, 10, 32'h99);
    tick(); idle(); dbg_addr = AW'(10);
    @(negedge clk);
    chk("dbg_x10_99", dbg_rdata, 32'h99);
    $display("step debug writes x10");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.pipeline_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NWR; i++) begin
        bus.wr_en[i]   = $urandom_range(0, 1) == 1;
        bus.wr_addr[i] = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? NREG - 1 : 7));
        bus.wr_data[i] = XLEN'($urandom);
      end
      bus.iss_en   = $urandom_range(0, 1) == 1;
      ra           = reg_addr_t'($urandom_range(0, 7));
      bus.iss_addr = ra;
      bus.flush    = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < NRD; j++) bus.rd_addr[j] = AW'($urandom_range(0, 7));
`ifdef REG_FILE_MP_DBG_PORT_EN
      dbg_en = $urandom_range(0, 3) == 0; dbg_we = $urandom_range(0, 1) == 1;
      dbg_addr = AW'($urandom_range(0, 7)); dbg_wdata = XLEN'($urandom);
`endif
      @(negedge clk);
      check_model($sformatf("rand%0d", n));
      $display("rand %0d en=%0b wr_en=%b iss=%0b@%0d flush=%0b rd=%0d,%0d data=%h,%h busy=%b",
               n, bus.pipeline_en, bus.wr_en, bus.iss_en, bus.iss_addr, bus.flush,
               bus.rd_addr[0], bus.rd_addr[1], bus.rd_data[0], bus.rd_data[1], bus.rd_busy);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
